lu_pipe_seq: RTL and testbench
==============================

# lu_pipe_seq

Sequencer for the LU block-update datapath (`cpu_pipeline`).
- Accepts one block command per handshake.
- Drives the pipeline's k/i/j read-counter controls and its per-token control bits (`valid`, `norm`, `recip`, write-target select, page), one token per cycle.
- Waits for pipeline drain at every data-dependency point (reciprocal → normalize → update → next k).
- Pulses done when the whole block has been written.

## Interface
Parameters:
- `IS_BPU`, "TRUE": normalizing (diagonal/left) commands supported. When "FALSE", `i_cmd_norm` is treated as 0.
- `BSIZE`, `BSIZEBITS`, `LANES`, `LANESBITS`: not parameters; taken from package `lu_new`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `i_cmd_valid` in 1: command offered.
- `o_cmd_ready` out 1: high only in IDLE.
- `i_cmd_norm` in 1: run the reciprocal and normalize phases before each update phase.
- `i_cmd_wr_sel` in 3: write-target mask {top, cur, left}, applied to every token.
- `i_cmd_page` in 1: page bit, applied to every token.
- `i_pause` in 1: suppress token issue and counter updates this cycle.
- `o_busy` out 1: state ≠ IDLE.
- `o_done` out 1: one-cycle pulse on FINISH → IDLE.
- `o_k_reset`, `o_k_inc` out 1 each: to the pipeline k counter.
- `o_i_reset`, `o_i_inc`, `o_i_load_k1` out 1 each: to the pipeline i counter.
- `o_j_reset`, `o_j_inc`, `o_j_load_k`, `o_j_load_k1` out 1 each: to the pipeline j counter.
- `i_k_done`, `i_i_done`, `i_j_done` in 1 each: counter status from the pipeline.
- `o_valid`, `o_norm`, `o_recip`, `o_wr_top`, `o_wr_cur`, `o_wr_left`, `o_whichpage` out 1 each: token controls.
- `i_pipe_empty` in 1: pipeline occupancy is zero.

## Operation
- States: IDLE, SETUP, RECIP, WAIT_R, NORM, WAIT_N, UPDATE, WAIT_U, FINISH.
- IDLE: `o_cmd_ready`=1. On `i_cmd_valid`:
  - latch norm (ANDed with IS_BPU), wr_sel and page;
  - pulse `o_k_reset`, `o_i_reset` and `o_j_reset`;
  - go to SETUP.
- SETUP (1 cycle):
  - Non-norm command with `i_k_done`: go to FINISH.
  - Otherwise assert `o_i_load_k1`.
  - Norm command: assert `o_j_load_k`, go to RECIP.
  - Non-norm command: assert `o_j_load_k1`, go to UPDATE.
- RECIP: issue one token with `o_valid`=`o_recip`=`o_norm`=1 and all write enables 0. Go to WAIT_R.
- WAIT_R: on drain, go to FINISH if `i_k_done`, else NORM.
- NORM: each cycle issue a token with `o_norm`=1 and the latched write mask.
  - If `!i_i_done`: assert `o_i_inc`.
  - If `i_i_done`: assert `o_i_load_k1` and `o_j_load_k1`, go to WAIT_N.
- WAIT_N: on drain, go to UPDATE.
- UPDATE: each cycle issue a token with `o_norm`=0.
  - `!i_i_done`: assert `o_i_inc`.
  - `i_i_done && !i_j_done`: assert `o_i_load_k1` and `o_j_inc`.
  - `i_i_done && i_j_done`: assert `o_k_inc`, go to WAIT_U.
- WAIT_U: on drain, go to SETUP.
- FINISH: on drain, pulse `o_done`, go to IDLE.
- Drain condition, all WAIT_* states and FINISH: leave only when `i_pipe_empty`=1 AND at least 2 cycles have been spent in the state. The first cycle is ignored because the pipeline's occupancy count lags `o_valid` by one cycle.
- Token fields:
  - `o_whichpage` = latched page.
  - `o_wr_*` = latched mask, except RECIP where all are 0.
  - `o_recip` is high only in RECIP.
- `i_pause`=1 in RECIP/NORM/UPDATE: no `o_valid`, no counter strobes, state held. In other states `i_pause` is ignored.
- Counter strobes are mutually exclusive per counter, within the priority order the pipeline implements.

## Timing
- Control outputs are combinational decodes of registered state, latched command bits and the `i_*_done`/`i_pause` inputs.
- The token issued in cycle t uses the counter values visible in cycle t. Strobes in cycle t update the counters at t+1.
- Throughput: 1 token/cycle within a phase.
- Phase overheads:
  - SETUP: 1 cycle per k.
  - Each drain: at least 2 cycles (more while the pipeline is non-empty).
  - FINISH: at least 2 cycles.
- While `reset`=1 (and the cycle after it, since state is IDLE), all outputs are 0 except that `o_cmd_ready` becomes 1 from the first cycle after reset.
- Reset mid-command: return to IDLE, latched fields cleared, no `o_done`.
- The pipeline counters are re-zeroed by the next command's reset pulse.

## Structure
- State enum `lu_seq_state_t` and the `WR_SEL` bit indices (TOP=2, CUR=1, LEFT=0) belong in `lu_new`.
- One sub-module is natural: `drain_wait`. It holds the 2-bit minimum-dwell counter and the empty check, and is shared by all WAIT_* states and FINISH.

## Test plan
Bench setup: BSIZE=32, LANES=8, bench counter model identical to the pipeline, pipeline modelled with a fixed token latency of 60.
- Non-norm command, page=1, wr_sel=3'b010 → k=0 issues 124 UPDATE tokens: j=1..31 × i∈{1,9,17,25}, all with `o_wr_cur`=1 and `o_whichpage`=1. The first token has j=1, i=1.
- Norm command → k=0 sequence is 1 RECIP token (j=0, no write enables), drain, then 4 NORM tokens (i=1,9,17,25, j=0), drain, then 124 UPDATE tokens.
- k=31 → non-norm: no tokens, FINISH, `o_done` once. Norm: 1 RECIP token then FINISH.
- `i_pause` held 5 cycles mid-UPDATE → 5 gap cycles, counters unchanged, total token count unchanged.
- Reset asserted during NORM → all outputs 0 on the following cycle, then `o_cmd_ready`=1, no `o_done`. A new command completes normally.
- `i_pipe_empty` held 1 in the first WAIT_U cycle → no transition until the second cycle.

Source files
------------

// File: rtl/lu_new_pkg.sv
// Shared definitions for the LU block-update datapath and its sequencer.
package lu_new;

    localparam int BSIZE     = 32;
    localparam int BSIZEBITS = 5;
    localparam int LANES     = 8;
    localparam int LANESBITS = 3;

    // Bit positions inside the {top, cur, left} write-target mask
    localparam int WR_SEL_TOP  = 2;
    localparam int WR_SEL_CUR  = 1;
    localparam int WR_SEL_LEFT = 0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SETUP  = 4'd1,
        ST_RECIP  = 4'd2,
        ST_WAIT_R = 4'd3,
        ST_NORM   = 4'd4,
        ST_WAIT_N = 4'd5,
        ST_UPDATE = 4'd6,
        ST_WAIT_U = 4'd7,
        ST_FINISH = 4'd8
    } lu_seq_state_t;

    // States that may only be left once the pipeline has drained
    function automatic logic is_drain_state(input lu_seq_state_t s);
        return (s == ST_WAIT_R) || (s == ST_WAIT_N) ||
               (s == ST_WAIT_U) || (s == ST_FINISH);
    endfunction

endpackage

// File: rtl/lu_pipe_seq_drain_wait.sv
// Minimum-dwell drain detector shared by every wait state of the sequencer.
// The pipeline's occupancy count lags the issued token by one cycle, so the
// empty flag is ignored during the first cycle spent in a wait state.
module drain_wait (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic pipe_empty,
    output logic drained
);

    logic [1:0] dwell;

    // Count cycles spent in the current wait state; restart on every exit
    always_ff @(posedge clk) begin
        if (reset || !active || drained) begin
            dwell <= 2'd0;
        end else if (dwell != 2'd3) begin
            dwell <= dwell + 2'd1;
        end
    end

    assign drained = active && pipe_empty && (dwell != 2'd0);

endmodule

// File: rtl/lu_pipe_seq.sv
// Sequencer for the LU block-update pipeline: walks the k/i/j counters through
// reciprocal, normalize and update phases, one token per cycle, with drains
// between data-dependent phases.
//
// Handshake: a command transfers on a cycle where i_cmd_valid and o_cmd_ready
// are both high; o_cmd_ready is high only in IDLE (and never while reset is
// high), and the command fields are latched on that same cycle.
module lu_pipe_seq
    import lu_new::*;
#(
    parameter string IS_BPU = "TRUE"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_norm,
    input  logic [2:0]    i_cmd_wr_sel,
    input  logic          i_cmd_page,
    input  logic          i_pause,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_k_reset,
    output logic          o_k_inc,
    output logic          o_i_reset,
    output logic          o_i_inc,
    output logic          o_i_load_k1,
    output logic          o_j_reset,
    output logic          o_j_inc,
    output logic          o_j_load_k,
    output logic          o_j_load_k1,
    input  logic          i_k_done,
    input  logic          i_i_done,
    input  logic          i_j_done,
    output logic          o_valid,
    output logic          o_norm,
    output logic          o_recip,
    output logic          o_wr_top,
    output logic          o_wr_cur,
    output logic          o_wr_left,
    output logic          o_whichpage,
    input  logic          i_pipe_empty,
    output lu_seq_state_t o_state
);

    localparam logic NORM_OK = (IS_BPU == "TRUE");

    lu_seq_state_t state;
    lu_seq_state_t state_next;

    logic       norm_q;
    logic [2:0] wr_sel_q;
    logic       page_q;

    logic       drain_active;
    logic       drained;
    logic       accept;

    assign accept       = !reset && (state == ST_IDLE) && i_cmd_valid;
    assign drain_active = is_drain_state(state);
    assign o_state      = state;

    drain_wait u_drain (
        .clk        (clk),
        .reset      (reset),
        .active     (drain_active),
        .pipe_empty (i_pipe_empty),
        .drained    (drained)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the command fields on acceptance; reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            norm_q   <= 1'b0;
            wr_sel_q <= 3'b000;
            page_q   <= 1'b0;
        end else if (accept) begin
            norm_q   <= i_cmd_norm && NORM_OK;
            wr_sel_q <= i_cmd_wr_sel;
            page_q   <= i_cmd_page;
        end
    end

    // Next-state and control decode; every output is held low while reset is high
    always_comb begin
        state_next  = state;
        o_cmd_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_k_reset   = 1'b0;
        o_k_inc     = 1'b0;
        o_i_reset   = 1'b0;
        o_i_inc     = 1'b0;
        o_i_load_k1 = 1'b0;
        o_j_reset   = 1'b0;
        o_j_inc     = 1'b0;
        o_j_load_k  = 1'b0;
        o_j_load_k1 = 1'b0;
        o_valid     = 1'b0;
        o_norm      = 1'b0;
        o_recip     = 1'b0;
        o_wr_top    = 1'b0;
        o_wr_cur    = 1'b0;
        o_wr_left   = 1'b0;
        o_whichpage = 1'b0;

        if (!reset) begin
            o_busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    o_cmd_ready = 1'b1;
                    if (i_cmd_valid) begin
                        o_k_reset  = 1'b1;
                        o_i_reset  = 1'b1;
                        o_j_reset  = 1'b1;
                        state_next = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!norm_q && i_k_done) begin
                        state_next = ST_FINISH;
                    end else begin
                        o_i_load_k1 = 1'b1;
                        if (norm_q) begin
                            o_j_load_k = 1'b1;
                            state_next = ST_RECIP;
                        end else begin
                            o_j_load_k1 = 1'b1;
                            state_next  = ST_UPDATE;
                        end
                    end
                end
                ST_RECIP: begin
                    if (!i_pause) begin
                        o_valid    = 1'b1;
                        o_recip    = 1'b1;
                        o_norm     = 1'b1;
                        state_next = ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (drained) begin
                        state_next = i_k_done ? ST_FINISH : ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (!i_pause) begin
                        o_valid = 1'b1;
                        o_norm  = 1'b1;
                        if (!i_i_done) begin
                            o_i_inc = 1'b1;
                        end else begin
                            o_i_load_k1 = 1'b1;
                            o_j_load_k1 = 1'b1;
                            state_next  = ST_WAIT_N;
                        end
                    end
                end
                ST_WAIT_N: begin
                    if (drained) begin
                        state_next = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (!i_pause) begin
                        o_valid = 1'b1;
                        if (!i_i_done) begin
                            o_i_inc = 1'b1;
                        end else if (!i_j_done) begin
                            o_i_load_k1 = 1'b1;
                            o_j_inc     = 1'b1;
                        end else begin
                            o_k_inc    = 1'b1;
                            state_next = ST_WAIT_U;
                        end
                    end
                end
                ST_WAIT_U: begin
                    if (drained) begin
                        state_next = ST_SETUP;
                    end
                end
                ST_FINISH: begin
                    if (drained) begin
                        o_done     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase

            // Token fields follow the issued token; reciprocal tokens write nothing
            if (o_valid) begin
                o_whichpage = page_q;
                if (!o_recip) begin
                    o_wr_top  = wr_sel_q[WR_SEL_TOP];
                    o_wr_cur  = wr_sel_q[WR_SEL_CUR];
                    o_wr_left = wr_sel_q[WR_SEL_LEFT];
                end
            end
        end
    end

endmodule

// File: tb/tb_lu_pipe_seq.sv
// Directed bench for lu_pipe_seq: counter/pipeline model, token monitor,
// and a linear sequence of command scenarios.
module tb_lu_pipe_seq;
    import lu_new::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // ---------------- DUT signals ----------------
    logic          cmd_valid = 1'b0, cmd_norm = 1'b0, cmd_page = 1'b0, pause = 1'b0;
    logic [2:0]    cmd_wr_sel = 3'b000;
    logic          o_cmd_ready, o_busy, o_done;
    logic          o_k_reset, o_k_inc, o_i_reset, o_i_inc, o_i_load_k1;
    logic          o_j_reset, o_j_inc, o_j_load_k, o_j_load_k1;
    logic          o_valid, o_norm, o_recip, o_wr_top, o_wr_cur, o_wr_left, o_whichpage;
    logic          k_done, i_done, j_done, pipe_empty;
    lu_seq_state_t o_state;

    lu_pipe_seq #(.IS_BPU("TRUE")) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_norm(cmd_norm),
        .i_cmd_wr_sel(cmd_wr_sel), .i_cmd_page(cmd_page), .i_pause(pause),
        .o_busy(o_busy), .o_done(o_done),
        .o_k_reset(o_k_reset), .o_k_inc(o_k_inc),
        .o_i_reset(o_i_reset), .o_i_inc(o_i_inc), .o_i_load_k1(o_i_load_k1),
        .o_j_reset(o_j_reset), .o_j_inc(o_j_inc), .o_j_load_k(o_j_load_k),
        .o_j_load_k1(o_j_load_k1),
        .i_k_done(k_done), .i_i_done(i_done), .i_j_done(j_done),
        .o_valid(o_valid), .o_norm(o_norm), .o_recip(o_recip),
        .o_wr_top(o_wr_top), .o_wr_cur(o_wr_cur), .o_wr_left(o_wr_left),
        .o_whichpage(o_whichpage), .i_pipe_empty(pipe_empty), .o_state(o_state)
    );

    logic [18:0] all_outs;
    assign all_outs = {o_cmd_ready, o_busy, o_done, o_k_reset, o_k_inc, o_i_reset,
                       o_i_inc, o_i_load_k1, o_j_reset, o_j_inc, o_j_load_k,
                       o_j_load_k1, o_valid, o_norm, o_recip, o_wr_top, o_wr_cur,
                       o_wr_left, o_whichpage};

    // ---------------- pipeline model: counters + 60-cycle token latency ----------------
    logic [5:0]  k_c = '0, i_c = '0, j_c = '0;
    logic [59:0] pipe_sr = '0;
    logic        empty_ovr = 1'b0;

    always @(posedge clk) begin
        if (o_k_reset) k_c <= '0;
        else if (o_k_inc) k_c <= k_c + 6'd1;
        if (o_i_reset) i_c <= '0;
        else if (o_i_load_k1) i_c <= k_c + 6'd1;
        else if (o_i_inc) i_c <= i_c + 6'(LANES);
        if (o_j_reset) j_c <= '0;
        else if (o_j_load_k) j_c <= k_c;
        else if (o_j_load_k1) j_c <= k_c + 6'd1;
        else if (o_j_inc) j_c <= j_c + 6'd1;
        pipe_sr <= {pipe_sr[58:0], o_valid};
    end

    assign k_done     = (k_c == 6'(BSIZE - 1));
    assign i_done     = (i_c >= 6'(BSIZE - LANES));
    assign j_done     = (j_c == 6'(BSIZE - 1));
    assign pipe_empty = (pipe_sr == '0) || empty_ovr;

    // ---------------- token monitor ----------------
    logic       exp_page = 1'b0;
    logic [2:0] exp_wr   = 3'b000;
    int n_tok = 0, n_upd = 0, n_norm = 0, n_recip = 0, n_done = 0, n_bad = 0;
    int n_upd_k0 = 0, n_norm_k0 = 0, n_tok_k31 = 0, n_recip_k31 = 0;
    logic [5:0] norm_i_k0 [4];

    always @(negedge clk) begin
        if (o_done) n_done++;
        if (o_valid) begin
            n_tok++;
            if (k_c == 6'd31) n_tok_k31++;
            if (o_whichpage !== exp_page) n_bad++;
            if (o_recip) begin
                n_recip++;
                if (k_c == 6'd31) n_recip_k31++;
                if ({o_wr_top, o_wr_cur, o_wr_left} !== 3'b000 || !o_norm) n_bad++;
            end else begin
                if ({o_wr_top, o_wr_cur, o_wr_left} !== exp_wr) n_bad++;
                if (o_norm) begin
                    n_norm++;
                    if (k_c == 6'd0) begin
                        if (n_norm_k0 < 4) norm_i_k0[n_norm_k0] = i_c;
                        n_norm_k0++;
                    end
                end else begin
                    n_upd++;
                    if (k_c == 6'd0) n_upd_k0++;
                end
            end
        end
    end

    // ---------------- scoreboard / checks ----------------
    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int b_tok, b_upd, b_norm, b_recip, b_done, b_bad, b_upd_k0, b_norm_k0, b_tok_k31, b_recip_k31;

    task automatic snap();
        b_tok = n_tok; b_upd = n_upd; b_norm = n_norm; b_recip = n_recip;
        b_done = n_done; b_bad = n_bad; b_upd_k0 = n_upd_k0; b_norm_k0 = n_norm_k0;
        b_tok_k31 = n_tok_k31; b_recip_k31 = n_recip_k31;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic norm, input logic [2:0] wr, input logic page);
        @(negedge clk);
        exp_wr = wr; exp_page = page;
        cmd_norm = norm; cmd_wr_sel = wr; cmd_page = page; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input lu_seq_state_t s, input int bound, input string tag);
        int n = 0;
        while (o_state !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_state), 32'(s));
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n = 0;
        while (o_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_valid), 32'd1);
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (n_done == b_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(tag, 32'(n_done - b_done), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] i0, j0;
        int n;

        // Reset: everything low while reset is high, ready once released
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(all_outs), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", 32'(all_outs), 32'h40000);
        chk("idle_state", 32'(o_state), 32'(ST_IDLE));

        // Run A: non-norm, page=1, cur only, with a 5-cycle pause mid-UPDATE
        snap();
        send_cmd(1'b0, 3'b010, 1'b1);
        wait_valid(10, "a_first_token");
        chk("a_first_ij", 32'({i_c, j_c}), 32'({6'd1, 6'd1}));
        chk("a_first_fields", 32'({o_norm, o_recip, o_wr_top, o_wr_cur, o_wr_left, o_whichpage}),
            32'(6'b000101));
        n = 0;
        while (n_upd - b_upd < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_reach_pause", 32'(n_upd - b_upd), 32'd10);
        pause = 1'b1;
        i0 = i_c; j0 = j_c;
        repeat (5) begin
            #1;
            chk("a_pause_hold", 32'({o_valid, o_state, i_c, j_c}),
                32'({1'b0, ST_UPDATE, i0, j0}));
            @(negedge clk);
        end
        pause = 1'b0;
        wait_done(20000, "a_done");
        chk("a_tokens", 32'(n_tok - b_tok), 32'd1512);
        chk("a_upd_k0", 32'(n_upd_k0 - b_upd_k0), 32'd124);
        chk("a_tok_k31", 32'(n_tok_k31 - b_tok_k31), 32'd0);
        chk("a_fields", 32'(n_bad - b_bad), 32'd0);
        chk("a_idle", 32'({o_cmd_ready, o_busy}), 32'b10);

        // Run B: norm, page=0, top+left, with the minimum-dwell check in WAIT_U
        snap();
        send_cmd(1'b1, 3'b101, 1'b0);
        wait_valid(10, "b_first_token");
        chk("b_recip_tok", 32'({o_recip, o_norm, o_wr_top, o_wr_cur, o_wr_left, j_c}),
            32'({5'b11000, 6'd0}));
        @(negedge clk);
        chk("b_wait_r", 32'({o_valid, o_state}), 32'({1'b0, ST_WAIT_R}));
        wait_valid(200, "b_norm_token");
        chk("b_norm_tok", 32'({o_recip, o_norm, o_wr_top, o_wr_cur, o_wr_left, i_c, j_c}),
            32'({5'b01101, 6'd1, 6'd0}));
        wait_state(ST_UPDATE, 300, "b_reach_update");
        empty_ovr = 1'b1;
        wait_state(ST_WAIT_U, 300, "b_reach_wait_u");
        @(negedge clk);
        chk("b_dwell_hold", 32'(o_state), 32'(ST_WAIT_U));
        @(negedge clk);
        chk("b_dwell_exit", 32'(o_state), 32'(ST_SETUP));
        empty_ovr = 1'b0;
        wait_done(40000, "b_done");
        chk("b_tokens", 32'(n_tok - b_tok), 32'd1620);
        chk("b_recips", 32'(n_recip - b_recip), 32'd32);
        chk("b_norms", 32'(n_norm - b_norm), 32'd76);
        chk("b_updates", 32'(n_upd - b_upd), 32'd1512);
        chk("b_norm_k0", 32'(n_norm_k0 - b_norm_k0), 32'd4);
        chk("b_upd_k0", 32'(n_upd_k0 - b_upd_k0), 32'd124);
        chk("b_k31_recip", 32'(n_recip_k31 - b_recip_k31), 32'd1);
        chk("b_k31_tokens", 32'(n_tok_k31 - b_tok_k31), 32'd1);
        chk("b_fields", 32'(n_bad - b_bad), 32'd0);
        exp_q = '{6'd1, 6'd9, 6'd17, 6'd25};
        for (int idx = 0; idx < 4; idx++) begin
            chk("b_norm_i", 32'(norm_i_k0[idx]), 32'(exp_q.pop_front()));
        end

        // Run C: reset while in NORM, no done pulse afterwards
        snap();
        send_cmd(1'b1, 3'b001, 1'b1);
        wait_state(ST_NORM, 300, "c_reach_norm");
        reset = 1'b1;
        @(negedge clk);
        chk("c_reset_state", 32'(o_state), 32'(ST_IDLE));
        chk("c_reset_outs", 32'(all_outs), 32'd0);
        reset = 1'b0;
        #1;
        chk("c_after_reset", 32'(all_outs), 32'h40000);
        repeat (200) @(negedge clk);
        chk("c_no_done", 32'(n_done - b_done), 32'd0);

        // Run D: a fresh non-norm command completes normally
        snap();
        send_cmd(1'b0, 3'b100, 1'b0);
        wait_done(20000, "d_done");
        chk("d_tokens", 32'(n_tok - b_tok), 32'd1512);
        chk("d_fields", 32'(n_bad - b_bad), 32'd0);
        chk("d_idle", 32'({o_cmd_ready, o_busy, o_state}), 32'({2'b10, ST_IDLE}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
